// File: rtl/bitser_feed.sv
// Parallel-to-serial feeder: takes a SIZE-bit word over valid/ready and emits it
// LSB first, one bit per beat, reloading back-to-back on the last beat.
module bitser_feed #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            out_last,
  output logic            busy
);

  // Counter is at least one bit wide so SIZE = 1 and 2 never produce an empty range.
  localparam int CW = (SIZE <= 2) ? 1 : $clog2(SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  if (SIZE < 1) begin : g_bad_size
    $fatal(1, "bitser_feed: SIZE must be >= 1");
  end

  logic [0:0]      state_q, state_d;
  logic [SIZE-1:0] sreg_q,  sreg_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic shifting, last, beat, accept;

  assign shifting  = (state_q == SHIFT);
  assign last      = shifting && (cnt_q == LAST_CNT);
  assign beat      = shifting && out_ready;
  // Ready in SHIFT comes straight from out_ready so the next word lands with no bubble.
  assign in_ready  = !shifting || (last && out_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid = shifting;
  assign out_bit   = shifting && sreg_q[0];
  assign out_last  = last;
  assign busy      = shifting;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = in_data;
      cnt_d   = '0;
    end else if (beat) begin
      sreg_d = sreg_q >> 1;
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bitser_feed.sv
// Directed bench for bitser_feed at SIZE = 1, 2, 4 and 8 with hand-computed bit streams.
module tb_bitser_feed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic       v1 = 0, r1 = 0, ir1, ov1, ob1, ol1, b1;
  logic [0:0] d1 = '0;
  logic       v2 = 0, r2 = 0, ir2, ov2, ob2, ol2, b2;
  logic [1:0] d2 = '0;
  logic       v4 = 0, r4 = 0, ir4, ov4, ob4, ol4, b4;
  logic [3:0] d4 = '0;
  logic       v8 = 0, r8 = 0, ir8, ov8, ob8, ol8, b8;
  logic [7:0] d8 = '0;

  bitser_feed #(.SIZE(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(r1), .out_bit(ob1), .out_last(ol1), .busy(b1));
  bitser_feed #(.SIZE(2)) u2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2),
    .out_valid(ov2), .out_ready(r2), .out_bit(ob2), .out_last(ol2), .busy(b2));
  bitser_feed #(.SIZE(4)) u4 (.clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_data(d4),
    .out_valid(ov4), .out_ready(r4), .out_bit(ob4), .out_last(ol4), .busy(b4));
  bitser_feed #(.SIZE(8)) u8 (.clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_data(d8),
    .out_valid(ov8), .out_ready(r8), .out_bit(ob8), .out_last(ol8), .busy(b8));

  task automatic chk(input string tag, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%b exp=%b @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] w4;
  logic [7:0] seq8;

  initial begin
    // reset state, all widths
    cyc();
    chk("rst_ir4", ir4, 1'b1); chk("rst_ov4", ov4, 1'b0); chk("rst_ob4", ob4, 1'b0);
    chk("rst_ol4", ol4, 1'b0); chk("rst_b4", b4, 1'b0);
    chk("rst_ir1", ir1, 1'b1); chk("rst_ov1", ov1, 1'b0);
    chk("rst_ir8", ir8, 1'b1); chk("rst_ov2", ov2, 1'b0);
    cyc();
    rst = 1'b0;

    // 1: single word 1011, free-running sink
    cyc(); v4 = 1; d4 = 4'b1011; r4 = 1; #1;
    chk("t1_ir_idle", ir4, 1'b1);
    w4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      cyc(); v4 = 0; d4 = 4'h0; #1;
      chk("t1_ov", ov4, 1'b1);
      chk("t1_bit", ob4, w4[i]);
      chk("t1_last", ol4, i == 3);
      chk("t1_ir", ir4, i == 3);
    end
    cyc(); #1;
    chk("t1_ov_end", ov4, 1'b0); chk("t1_ir_end", ir4, 1'b1); chk("t1_busy_end", b4, 1'b0);

    // 2: A then 5 back-to-back -> 0,1,0,1,1,0,1,0
    cyc(); v4 = 1; d4 = 4'hA; #1;
    seq8 = 8'b0101_1010;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) d4 = 4'h5;
      if (k == 4) v4 = 0;
      #1;
      chk("t2_ov", ov4, 1'b1);
      chk("t2_bit", ob4, seq8[k]);
      chk("t2_ir", ir4, (k == 3) || (k == 7));
      chk("t2_last", ol4, (k == 3) || (k == 7));
    end
    cyc(); #1;
    chk("t2_ov_end", ov4, 1'b0);

    // 3: 0110 with a 3-cycle stall after beat 1
    cyc(); v4 = 1; d4 = 4'b0110; #1;
    cyc(); v4 = 0; #1;
    chk("t3_b0", ob4, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cyc(); r4 = 0; d4 = 4'(s + 9); #1;
      chk("t3_stall_bit", ob4, 1'b1);
      chk("t3_stall_ov", ov4, 1'b1);
      chk("t3_stall_last", ol4, 1'b0);
      chk("t3_stall_ir", ir4, 1'b0);
    end
    cyc(); r4 = 1; #1;
    chk("t3_b1", ob4, 1'b1); chk("t3_b1_last", ol4, 1'b0);
    cyc(); #1;
    chk("t3_b2", ob4, 1'b1); chk("t3_b2_last", ol4, 1'b0);
    cyc(); #1;
    chk("t3_b3", ob4, 1'b0); chk("t3_b3_last", ol4, 1'b1);
    cyc(); #1;
    chk("t3_ov_end", ov4, 1'b0);

    // 4: SIZE=1 streaming 1,0,1
    cyc(); v1 = 1; d1 = 1'b1; r1 = 1; #1;
    chk("t4_ir0", ir1, 1'b1);
    cyc(); d1 = 1'b0; #1;
    chk("t4_b0", ob1, 1'b1); chk("t4_l0", ol1, 1'b1); chk("t4_ir1", ir1, 1'b1);
    cyc(); d1 = 1'b1; #1;
    chk("t4_b1", ob1, 1'b0); chk("t4_l1", ol1, 1'b1); chk("t4_ir2", ir1, 1'b1);
    chk("t4_cnt", u1.cnt_q[0], 1'b0);
    cyc(); v1 = 0; #1;
    chk("t4_b2", ob1, 1'b1); chk("t4_l2", ol1, 1'b1); chk("t4_ir3", ir1, 1'b1);
    cyc(); #1;
    chk("t4_ov_end", ov1, 1'b0);

    // 5: SIZE=2, word 10
    cyc(); v2 = 1; d2 = 2'b10; r2 = 1; #1;
    cyc(); v2 = 0; #1;
    chk("t5_b0", ob2, 1'b0); chk("t5_l0", ol2, 1'b0); chk("t5_c0", u2.cnt_q[0], 1'b0);
    cyc(); #1;
    chk("t5_b1", ob2, 1'b1); chk("t5_l1", ol2, 1'b1); chk("t5_c1", u2.cnt_q[0], 1'b1);
    cyc(); #1;
    chk("t5_ov_end", ov2, 1'b0); chk("t5_c_end", u2.cnt_q[0], 1'b0);

    // 6: SIZE=8, async reset after beat 3 of FF, then 01
    cyc(); v8 = 1; d8 = 8'hFF; r8 = 1; #1;
    cyc(); v8 = 0; #1;
    chk("t6_b0", ob8, 1'b1);
    repeat (3) cyc();
    #2; rst = 1; #1;
    chk("t6_rst_ov", ov8, 1'b0); chk("t6_rst_busy", b8, 1'b0);
    chk("t6_rst_ir", ir8, 1'b1); chk("t6_rst_bit", ob8, 1'b0);
    cyc(); rst = 0; v8 = 1; d8 = 8'h01; #1;
    chk("t6_ir_fresh", ir8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(); v8 = 0; #1;
      chk("t6_bit", ob8, i == 0);
      chk("t6_last", ol8, i == 7);
      chk("t6_ov", ov8, 1'b1);
    end
    cyc(); #1;
    chk("t6_ov_end", ov8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
